// File: rtl/la_iopwrseq_pkg.sv
// Shared types for the IO-ring power sequencer: FSM state encoding and
// the index-width helper used to size the sequencing index register.
package la_iopwrseq_pkg;

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_UP    = 3'd1,
    ST_ON    = 3'd2,
    ST_DOWN  = 3'd3,
    ST_FAULT = 3'd4
  } state_e;

  // Index register width: enough bits to address RINGW lines, never zero.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/la_iopwrseq_timer.sv
// Loadable DW-bit down-counter that paces the sequencer; expire flags the
// last cycle of a step (count == 1).
module la_iopwrseq_timer #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          en,
  input  logic [DW-1:0] load_val,
  output logic [DW-1:0] value,
  output logic          expire
);

  logic [DW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en) begin
      cnt_d = cnt_q - DW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its pre-edge inputs regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign value  = cnt_q;
  assign expire = (cnt_q == DW'(1));

endmodule

// File: rtl/la_iopwrseq.sv
// IO-ring power/enable sequencer: raises the ring control lines one at a
// time on power-up, drops them in reverse on power-down, and kills all on fault.
module la_iopwrseq
  import la_iopwrseq_pkg::*;
#(
  parameter int RINGW = 8,
  parameter int DW    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             fault,
  input  logic [DW-1:0]    step_delay,
  output logic [RINGW-1:0] ctrl,
  output logic             ack,
  output logic             busy,
  output logic             fault_flag
);

  localparam int             IW      = idx_width(RINGW);
  localparam logic [IW-1:0]  IDX_TOP = IW'(RINGW - 1);

  state_e           state_q, state_d;
  logic [RINGW-1:0] ctrl_q, ctrl_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             ack_q, ack_d;
  logic             busy_q, busy_d;
  logic             fault_flag_q, fault_flag_d;

  logic [DW-1:0]    step_len;
  logic             tmr_load;
  logic             tmr_en;
  logic [DW-1:0]    tmr_value;
  logic             tmr_expire;

  // A zero step delay would stall the counter, so it is promoted to one.
  assign step_len = (step_delay == '0) ? DW'(1) : step_delay;

  // The counter only runs while sequencing and stops at zero rather than wrap.
  assign tmr_en = ((state_q == ST_UP) || (state_q == ST_DOWN)) && (tmr_value != '0);

  la_iopwrseq_timer #(
    .DW(DW)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (tmr_load),
    .en      (tmr_en),
    .load_val(step_len),
    .value   (tmr_value),
    .expire  (tmr_expire)
  );

  // NOTE: every signal assigned here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    ctrl_d       = ctrl_q;
    idx_d        = idx_q;
    fault_flag_d = fault_flag_q;
    tmr_load     = 1'b0;

    if (fault) begin
      state_d      = ST_FAULT;
      ctrl_d       = '0;
      idx_d        = '0;
      fault_flag_d = 1'b1;
    end else begin
      unique case (state_q)
        ST_OFF: begin
          if (req) begin
            state_d  = ST_UP;
            ctrl_d   = RINGW'(1);
            idx_d    = '0;
            tmr_load = 1'b1;
          end
        end
        ST_UP: begin
          // Lines are always a contiguous run from bit 0, so shifting right
          // clears exactly the highest lit line.
          if (!req) begin
            state_d  = ST_DOWN;
            ctrl_d   = ctrl_q >> 1;
            tmr_load = 1'b1;
          end else if (tmr_expire) begin
            if (idx_q != IDX_TOP) begin
              ctrl_d   = (ctrl_q << 1) | RINGW'(1);
              idx_d    = idx_q + IW'(1);
              tmr_load = 1'b1;
            end else begin
              state_d = ST_ON;
            end
          end
        end
        ST_ON: begin
          if (!req) begin
            state_d  = ST_DOWN;
            ctrl_d   = ctrl_q >> 1;
            idx_d    = IDX_TOP;
            tmr_load = 1'b1;
          end
        end
        ST_DOWN: begin
          // A re-raised req is deliberately ignored until OFF is reached.
          if (tmr_expire) begin
            if (idx_q != '0) begin
              ctrl_d   = ctrl_q >> 1;
              idx_d    = idx_q - IW'(1);
              tmr_load = 1'b1;
            end else begin
              state_d = ST_OFF;
            end
          end
        end
        ST_FAULT: begin
          ctrl_d = '0;
          if (!req) begin
            state_d      = ST_OFF;
            fault_flag_d = 1'b0;
          end
        end
        default: begin
          state_d = ST_OFF;
          ctrl_d  = '0;
          idx_d   = '0;
        end
      endcase
    end

    ack_d  = (state_d == ST_ON);
    busy_d = (state_d == ST_UP) || (state_d == ST_DOWN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_OFF;
      ctrl_q       <= '0;
      idx_q        <= '0;
      ack_q        <= 1'b0;
      busy_q       <= 1'b0;
      fault_flag_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ctrl_q       <= ctrl_d;
      idx_q        <= idx_d;
      ack_q        <= ack_d;
      busy_q       <= busy_d;
      fault_flag_q <= fault_flag_d;
    end
  end

  assign ctrl       = ctrl_q;
  assign ack        = ack_q;
  assign busy       = busy_q;
  assign fault_flag = fault_flag_q;

endmodule

// File: tb/tb_la_iopwrseq.sv
// Self-checking bench for la_iopwrseq: directed timing scenarios plus a
// randomized run, all compared against a lit-count/remaining-edges model.
module tb_la_iopwrseq;

  localparam int RINGW = 4;
  localparam int DW    = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             req;
  logic             fault;
  logic [DW-1:0]    step_delay;
  logic [RINGW-1:0] ctrl;
  logic             ack;
  logic             busy;
  logic             fault_flag;

  always #5 clk = ~clk;

  la_iopwrseq #(
    .RINGW(RINGW),
    .DW   (DW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .fault     (fault),
    .step_delay(step_delay),
    .ctrl      (ctrl),
    .ack       (ack),
    .busy      (busy),
    .fault_flag(fault_flag)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model: ring described by how many lines are lit and how many edges
  // remain before the next step.
  typedef enum {M_OFF, M_UP, M_ON, M_DOWN, M_FAULT} mode_e;
  mode_e m_mode = M_OFF;
  int    m_lit  = 0;
  int    m_wait = 0;
  bit    m_flag = 1'b0;

  logic [RINGW-1:0] hist_ctrl [0:31];
  logic             hist_ack  [0:31];
  logic             hist_busy [0:31];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_step();
    int d;
    d = (step_delay == 0) ? 1 : int'(step_delay);
    if (reset) begin
      m_mode = M_OFF; m_lit = 0; m_wait = 0; m_flag = 1'b0;
    end else if (fault) begin
      m_mode = M_FAULT; m_lit = 0; m_flag = 1'b1;
    end else begin
      case (m_mode)
        M_OFF: if (req) begin m_mode = M_UP; m_lit = 1; m_wait = d; end
        M_UP: begin
          if (!req) begin m_mode = M_DOWN; m_lit--; m_wait = d; end
          else if (m_wait == 1) begin
            if (m_lit < RINGW) begin m_lit++; m_wait = d; end
            else m_mode = M_ON;
          end else m_wait--;
        end
        M_ON: if (!req) begin m_mode = M_DOWN; m_lit = RINGW - 1; m_wait = d; end
        M_DOWN: begin
          if (m_wait == 1) begin
            if (m_lit > 0) begin m_lit--; m_wait = d; end
            else m_mode = M_OFF;
          end else m_wait--;
        end
        M_FAULT: if (!req) begin m_mode = M_OFF; m_flag = 1'b0; end
        default: m_mode = M_OFF;
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("ctrl",       32'(ctrl),       32'((1 << m_lit) - 1));
    check("ack",        32'(ack),        32'(m_mode == M_ON));
    check("busy",       32'(busy),       32'(m_mode == M_UP || m_mode == M_DOWN));
    check("fault_flag", 32'(fault_flag), 32'(m_flag));
  endtask

  // Records outputs at edges 1..n after the most recent input change.
  task automatic run_rec(input int n);
    for (int i = 1; i <= n; i++) begin
      tick();
      hist_ctrl[i] = ctrl;
      hist_ack[i]  = ack;
      hist_busy[i] = busy;
    end
  endtask

  task automatic wait_ack(input int limit);
    for (int i = 0; i < limit && ack !== 1'b1; i++) tick();
    check("ack_timeout", 32'(ack), 32'd1);
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; fault = 1'b0; step_delay = 8'd3;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_ctrl", 32'(ctrl), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // Power-up, D=3
    req = 1'b1;
    run_rec(13);
    check("up_b0",     32'(hist_ctrl[1]),  32'h1);
    check("up_hold",   32'(hist_ctrl[3]),  32'h1);
    check("up_b1",     32'(hist_ctrl[4]),  32'h3);
    check("up_b2",     32'(hist_ctrl[7]),  32'h7);
    check("up_b3",     32'(hist_ctrl[10]), 32'hf);
    check("up_ack_pre",32'(hist_ack[12]),  32'd0);
    check("up_ack",    32'(hist_ack[13]),  32'd1);
    check("up_busy1",  32'(hist_busy[1]),  32'd1);
    check("up_busy12", 32'(hist_busy[12]), 32'd1);
    check("up_busy13", 32'(hist_busy[13]), 32'd0);
    repeat (3) tick();

    // Power-down from ON, D=3
    req = 1'b0;
    run_rec(13);
    check("dn_first",  32'(hist_ctrl[1]),  32'h7);
    check("dn_ack",    32'(hist_ack[1]),   32'd0);
    check("dn_b2",     32'(hist_ctrl[4]),  32'h3);
    check("dn_b1",     32'(hist_ctrl[7]),  32'h1);
    check("dn_b0",     32'(hist_ctrl[10]), 32'h0);
    check("dn_busy12", 32'(hist_busy[12]), 32'd1);
    check("dn_busy13", 32'(hist_busy[13]), 32'd0);

    // step_delay=0 behaves as 1
    step_delay = 8'd0;
    req = 1'b1;
    run_rec(5);
    check("d0_b0",  32'(hist_ctrl[1]), 32'h1);
    check("d0_b1",  32'(hist_ctrl[2]), 32'h3);
    check("d0_b2",  32'(hist_ctrl[3]), 32'h7);
    check("d0_b3",  32'(hist_ctrl[4]), 32'hf);
    check("d0_pre", 32'(hist_ack[4]),  32'd0);
    check("d0_ack", 32'(hist_ack[5]),  32'd1);
    req = 1'b0;
    run_rec(6);
    check("d0_dn_idle", 32'(hist_busy[5]), 32'd0);

    // Abort mid-UP, then re-raise req during DOWN
    step_delay = 8'd3;
    req = 1'b1;
    run_rec(4);
    check("ab_at", 32'(hist_ctrl[4]), 32'h3);
    req = 1'b0;
    run_rec(2);
    check("ab_clear", 32'(hist_ctrl[1]), 32'h1);
    req = 1'b1;
    run_rec(6);
    check("ab_norev",  32'(hist_ctrl[1]), 32'h1);
    check("ab_zero",   32'(hist_ctrl[2]), 32'h0);
    check("ab_off",    32'(hist_busy[5]), 32'd0);
    check("ab_re_b0",  32'(hist_ctrl[6]), 32'h1);
    check("ab_re_bsy", 32'(hist_busy[6]), 32'd1);
    wait_ack(100);

    // Fault while ON
    fault = 1'b1;
    tick();
    check("flt_ctrl", 32'(ctrl),       32'h0);
    check("flt_ack",  32'(ack),        32'd0);
    check("flt_flag", 32'(fault_flag), 32'd1);
    fault = 1'b0;
    repeat (3) tick();
    check("flt_hold", 32'(fault_flag), 32'd1);
    req = 1'b0;
    tick();
    check("flt_clr",  32'(fault_flag), 32'd0);
    check("flt_busy", 32'(busy),       32'd0);
    tick();

    // Reset pulsed mid-UP
    req = 1'b1;
    run_rec(4);
    check("rs_at", 32'(hist_ctrl[4]), 32'h3);
    reset = 1'b1;
    tick();
    check("rs_ctrl", 32'(ctrl), 32'h0);
    check("rs_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    tick();
    check("rs_restart", 32'(ctrl), 32'h1);

    // Randomized run
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 29) == 0) req = ~req;
      fault = ($urandom_range(0, 149) == 0);
      reset = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 49) == 0)
        step_delay = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 5));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
